cyclo_phase_rotator_gen: RTL

- Streaming generator of the FAM down-conversion coefficients exp(-j2π·m·p·L/Np) for the cyclostationary front end.
- Sits beside the channelizer FFT output. Emits one complex coefficient per accepted FFT sample, in lock-step with the FFT stream.
- Successor to the fixed-size table generator:
  - runtime-selectable Np (16..NP_MAX) and L;
  - quarter-wave ROM with symmetry instead of a full P×Np table;
  - incremental phase arithmetic;
  - AXI-Stream backpressure and frame framing.

---
 rtl/cyclo_phase_rotator_gen_pkg.sv | 47 ++++
 rtl/cyclo_phase_rotator_gen_if.sv | 29 ++
 rtl/cyclo_phase_rotator_gen_rom.sv | 56 +++++
 rtl/cyclo_phase_rotator_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cyclo_phase_rotator_gen_pkg.sv
// Shared definitions for the cyclostationary phase-rotator generator.
// Holds the default sizes, the configuration decode and clamp helpers,
// and the frame-sequencing state enum.
package cr_cyclo_pkg;

  localparam int NP_MAX_DEF  = 1024;
  localparam int P_MAX_DEF   = 1024;
  localparam int NB_COEF_DEF = 10;

  // Np = 16 << sel, so the smallest block is 2^4.
  localparam int         NP_MIN_LOG2    = 4;
  localparam logic [2:0] NFFT_SEL_CLAMP = 3'd7;

  // L = 1 << sel, with sel held inside 2..8 (L = 4..256).
  localparam logic [3:0] L_SEL_MIN = 4'd2;
  localparam logic [3:0] L_SEL_MAX = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // log2(Np) for a block-size select. Selects past the largest supported
  // block, and the explicit clamp code, both land on log2(NP_MAX).
  function automatic int np_log2_f(input logic [2:0] sel, input int np_max_log2);
    int l;
    l = NP_MIN_LOG2 + int'(sel);
    if ((sel == NFFT_SEL_CLAMP) || (l > np_max_log2)) begin
      return np_max_log2;
    end else begin
      return l;
    end
  endfunction

  // Pull an out-of-range L select into the legal 2..8 window.
  function automatic logic [3:0] l_sel_clamp_f(input logic [3:0] sel);
    if (sel < L_SEL_MIN) begin
      return L_SEL_MIN;
    end else if (sel > L_SEL_MAX) begin
      return L_SEL_MAX;
    end else begin
      return sel;
    end
  endfunction

endpackage

// File: rtl/cyclo_phase_rotator_gen_if.sv
// Streaming interface of the phase-rotator generator.
//   i_s_axis_tvalid / o_s_axis_tready : FFT-sample index handshake
//   o_m_axis_tvalid / i_m_axis_tready : coefficient handshake
//   o_exp_real / o_exp_imag           : coefficient, two's complement Q(NB_COEF-1)
//   o_m_axis_tlast                    : last coefficient of each block
// The slave modport is the generator side, master is the environment side.
interface cyclo_phase_rotator_gen_if
  import cr_cyclo_pkg::*;
#(
  parameter int NB_COEF = NB_COEF_DEF
);
  logic                      i_s_axis_tvalid;
  logic                      o_s_axis_tready;
  logic                      o_m_axis_tvalid;
  logic                      i_m_axis_tready;
  logic                      o_m_axis_tlast;
  logic signed [NB_COEF-1:0] o_exp_real;
  logic signed [NB_COEF-1:0] o_exp_imag;

  modport slave (
    input  i_s_axis_tvalid, i_m_axis_tready,
    output o_s_axis_tready, o_m_axis_tvalid, o_m_axis_tlast, o_exp_real, o_exp_imag
  );

  modport master (
    output i_s_axis_tvalid, i_m_axis_tready,
    input  o_s_axis_tready, o_m_axis_tvalid, o_m_axis_tlast, o_exp_real, o_exp_imag
  );
endinterface

// File: rtl/cyclo_phase_rotator_gen_rom.sv
// Quarter-wave cosine ROM with two synchronous read ports.
//   clk, rst          : clock, asynchronous active-high reset
//   en_i              : read enable; outputs hold when low
//   addr_a_i/addr_b_i : indices 0..NP_MAX/4
//   data_a_o/data_b_o : C[addr] = round(cos(2*pi*addr/NP_MAX) * 2^(NB_COEF-1)), saturated
module exp_quarter_rom #(
  parameter int NP_MAX  = 1024,
  parameter int NB_COEF = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_i,
  input  logic [$clog2(NP_MAX)-2:0]     addr_a_i,
  input  logic [$clog2(NP_MAX)-2:0]     addr_b_i,
  output logic signed [NB_COEF-1:0]     data_a_o,
  output logic signed [NB_COEF-1:0]     data_b_o
);
  localparam int Q = NP_MAX / 4;

  // Entry value for index i. cos(0) scales to 2^(NB_COEF-1), one past the
  // largest positive code, so it saturates to 2^(NB_COEF-1)-1.
  function automatic logic signed [NB_COEF-1:0] coef_f(input int i);
    real x;
    int  v;
    int  vmax;
    vmax = (1 << (NB_COEF - 1)) - 1;
    x    = $cos(2.0 * 3.14159265358979323846 * real'(i) / real'(NP_MAX))
           * real'(1 << (NB_COEF - 1));
    v    = int'(x);
    if (v > vmax) begin
      v = vmax;
    end else if (v < -vmax) begin
      v = -vmax;
    end else begin
      v = v;
    end
    return NB_COEF'(v);
  endfunction

  logic signed [NB_COEF-1:0] rom_s [0:Q];

  for (genvar gi = 0; gi <= Q; gi++) begin : g_rom
    assign rom_s[gi] = coef_f(gi);
  end

  // Registered dual read; holds while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_a_o <= '0;
      data_b_o <= '0;
    end else if (en_i) begin
      data_a_o <= rom_s[addr_a_i];
      data_b_o <= rom_s[addr_b_i];
    end
  end
endmodule

// File: rtl/cyclo_phase_rotator_gen.sv
// Streaming generator of the FAM down-conversion coefficients
// exp(-j*2*pi*m*p*L/Np), one per accepted FFT sample.
//   clock, i_reset           : clock, asynchronous active-high reset
//   i_enable                 : 0 pauses acceptance, in-flight data still drains
//   i_start                  : frame start, sampled in IDLE only
//   i_NFFT_sel/i_L_sel/i_P_blocks : frame configuration, latched at start
//   axis (slave)             : sample-index input / coefficient output stream
//   o_frame_done             : one-cycle pulse after the last coefficient transfers
//   o_busy                   : high while a frame is running or draining
// Pipeline: address register -> quarter-ROM read -> quadrant sign/swap register.
module cyclo_phase_rotator_gen
  import cr_cyclo_pkg::*;
#(
  parameter int NP_MAX  = NP_MAX_DEF,
  parameter int P_MAX   = P_MAX_DEF,
  parameter int NB_COEF = NB_COEF_DEF
) (
  input  logic                     clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_start,
  input  logic [2:0]               i_NFFT_sel,
  input  logic [3:0]               i_L_sel,
  input  logic [$clog2(P_MAX):0]   i_P_blocks,
  cyclo_phase_rotator_gen_if.slave axis,
  output logic                     o_frame_done,
  output logic                     o_busy
);
  localparam int AW  = $clog2(NP_MAX);
  localparam int PW  = $clog2(P_MAX) + 1;
  localparam int SW  = $clog2(AW + 1);
  localparam int RW1 = AW - 1;
  localparam int Q   = NP_MAX / 4;

  state_e          state_q;
  logic [AW-1:0]   mask_q, lstep_q, m_q, step_q, acc_q;
  logic [SW-1:0]   shift_q;
  logic [PW-1:0]   pblk_q, p_q;
  logic            busy_q, done_q;

  logic            v1_q, last1_q, v2_q, last2_q, v3_q, last3_q;
  logic [AW-1:0]   a1_q;
  logic [1:0]      q2_q;
  logic signed [NB_COEF-1:0] re_q, im_q;

  logic [AW-1:0]   mask_d, lstep_d;
  logic [SW-1:0]   shift_d;
  logic [PW-1:0]   pblk_d;
  logic [RW1-1:0]  addr_a_s, addr_b_s;
  logic signed [NB_COEF-1:0] c_r_s, c_qr_s, re_s, im_s;
  logic            advance_s, tready_s, accept_s, blk_end_s, frm_end_s;
  int              np_log2_s;

  // Any stage may move only when the output register is free to change.
  assign advance_s = !(v3_q && !axis.i_m_axis_tready);
  assign tready_s  = (state_q == ST_RUN) && i_enable && advance_s;
  assign accept_s  = tready_s && axis.i_s_axis_tvalid;
  assign blk_end_s = (m_q == mask_q);
  assign frm_end_s = blk_end_s && (p_q == (pblk_q - PW'(1)));

  assign axis.o_s_axis_tready = tready_s;
  assign axis.o_m_axis_tvalid = v3_q;
  assign axis.o_m_axis_tlast  = last3_q;
  assign axis.o_exp_real      = re_q;
  assign axis.o_exp_imag      = im_q;
  assign o_frame_done         = done_q;
  assign o_busy               = busy_q;

  // Clamp and decode the frame configuration presented at start.
  always_comb begin
    np_log2_s = np_log2_f(i_NFFT_sel, AW);
    mask_d    = AW'((32'd1 << np_log2_s) - 32'd1);
    shift_d   = SW'(AW - np_log2_s);
    lstep_d   = AW'(32'd1 << l_sel_clamp_f(i_L_sel));
    if (i_P_blocks == '0) begin
      pblk_d = PW'(1);
    end else if (i_P_blocks > PW'(P_MAX)) begin
      pblk_d = PW'(P_MAX);
    end else begin
      pblk_d = i_P_blocks;
    end
  end

  // Frame sequencing and incremental phase: acc = m*step, step = p*L (mod Np).
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      lstep_q <= '0;
      shift_q <= '0;
      pblk_q  <= '0;
      m_q     <= '0;
      p_q     <= '0;
      step_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start && i_enable) begin
            mask_q  <= mask_d;
            lstep_q <= lstep_d;
            shift_q <= shift_d;
            pblk_q  <= pblk_d;
            m_q     <= '0;
            p_q     <= '0;
            step_q  <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            if (blk_end_s) begin
              m_q    <= '0;
              acc_q  <= '0;
              step_q <= (step_q + lstep_q) & mask_q;
              p_q    <= p_q + PW'(1);
              if (frm_end_s) begin
                state_q <= ST_DRAIN;
              end
            end else begin
              m_q   <= m_q + AW'(1);
              acc_q <= (acc_q + step_q) & mask_q;
            end
          end
        end
        ST_DRAIN: begin
          // Finish on the edge where the final coefficient leaves the output.
          if (!v1_q && !v2_q && (!v3_q || axis.i_m_axis_tready)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Quarter-wave lookup: r indexes the cosine, Q-r gives the sine.
  assign addr_a_s = {1'b0, a1_q[AW-3:0]};
  assign addr_b_s = RW1'(Q) - addr_a_s;

  exp_quarter_rom #(
    .NP_MAX  (NP_MAX),
    .NB_COEF (NB_COEF)
  ) u_rom (
    .clk      (clock),
    .rst      (i_reset),
    .en_i     (advance_s),
    .addr_a_i (addr_a_s),
    .addr_b_i (addr_b_s),
    .data_a_o (c_r_s),
    .data_b_o (c_qr_s)
  );

  // Quadrant sign/swap; imaginary output is -sin for the conjugate rotation.
  always_comb begin
    re_s = '0;
    im_s = '0;
    case (q2_q)
      2'd0: begin re_s =  c_r_s;  im_s = -c_qr_s; end
      2'd1: begin re_s = -c_qr_s; im_s = -c_r_s;  end
      2'd2: begin re_s = -c_r_s;  im_s =  c_qr_s; end
      2'd3: begin re_s =  c_qr_s; im_s =  c_r_s;  end
      default: begin re_s = '0; im_s = '0; end
    endcase
  end

  // Three-stage pipeline; every stage holds together under backpressure.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      last1_q <= 1'b0;
      v2_q    <= 1'b0;
      q2_q    <= '0;
      last2_q <= 1'b0;
      v3_q    <= 1'b0;
      last3_q <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else if (advance_s) begin
      v1_q    <= accept_s;
      a1_q    <= acc_q << shift_q;
      last1_q <= accept_s && blk_end_s;
      v2_q    <= v1_q;
      q2_q    <= a1_q[AW-1 -: 2];
      last2_q <= last1_q;
      v3_q    <= v2_q;
      last3_q <= last2_q;
      re_q    <= re_s;
      im_q    <= im_s;
    end
  end
endmodule
